// File: rtl/timer_pkg.sv
// timer_pkg: shared types and constants for the BCD countdown timer.
package timer_pkg;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;
endpackage

// File: rtl/bcd_down_digit.sv
// bcd_down_digit: one mod-10 down-counting BCD stage with borrow output.
// Ports: clk, rst (sync, active-high); load/d parallel load; dec_en decrement
// request; q current digit; borrow_out asserted when decrementing through 0.
module bcd_down_digit
  import timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [BCD_W-1:0] d,
  input  logic             dec_en,
  output logic [BCD_W-1:0] q,
  output logic             borrow_out
);
  logic [BCD_W-1:0] q_q, q_d;
  always_comb q_d = load ? d : dec_en ? (q_q == '0 ? BCD_MAX : q_q - 4'd1) : q_q;
  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else q_q <= q_d;
  end
  assign q = q_q;
  assign borrow_out = dec_en && q_q == '0;
endmodule

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: multi-digit BCD down-counter with load/start/pause/done control.
// Ports: clk, rst (sync, active-high); load/load_val BCD load request; start,
// pause run control; Q registered count; busy (RUN or PAUSED); done one-cycle
// pulse on reaching zero; load_err one-cycle pulse on a rejected (non-BCD) load.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int DIGITS     = 2,
  parameter int PRESCALE   = 1,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  input  logic                  start,
  input  logic                  pause,
  output logic [BCD_W*DIGITS-1:0] Q,
  output logic                  busy,
  output logic                  done,
  output logic                  load_err
);
  localparam int W = BCD_W * DIGITS;
  state_t state_q, state_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic busy_q, done_q, done_d, load_err_q, load_err_d;
  logic valid, can_load, load_ok, tick, stop;
  logic [DIGITS:0] borrow;
  always_comb begin
    valid = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (load_val[i*BCD_W +: BCD_W] > BCD_MAX) valid = 1'b0;
  end
  assign can_load = state_q != ST_RUN;
  assign load_ok  = load && can_load && valid;
  // A pause request preempts the decrement on the edge that enters PAUSED.
  assign tick     = state_q == ST_RUN && !pause && presc_q == PRESCALE_W'(PRESCALE - 1);
  // The top borrow would mean decrementing through zero; treat it as a stop too.
  assign stop     = tick && (Q == W'(1) || borrow[DIGITS]);
  assign borrow[0] = tick;
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_down_digit u_digit (
      .clk       (clk),
      .rst       (rst),
      .load      (load_ok),
      .d         (load_val[g*BCD_W +: BCD_W]),
      .dec_en    (borrow[g]),
      .q         (Q[g*BCD_W +: BCD_W]),
      .borrow_out(borrow[g+1])
    );
  end
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    done_d     = 1'b0;
    load_err_d = load && can_load && !valid;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !load && Q != '0) begin
          state_d = ST_RUN;
          presc_d = '0;
        end
      end
      ST_RUN: begin
        if (pause) state_d = ST_PAUSED;
        else begin
          presc_d = tick ? '0 : presc_q + PRESCALE_W'(1);
          if (stop) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_PAUSED: begin
        // Any load on the resume edge takes priority over start.
        presc_d = load_ok ? '0 : presc_q;
        if (start && !pause && !load) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      busy_q     <= state_d != ST_IDLE;
      done_q     <= done_d;
      load_err_q <= load_err_d;
    end
  end
  assign busy     = busy_q;
  assign done     = done_q;
  assign load_err = load_err_q;
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb_bcd_countdown_timer: directed self-checking bench for bcd_countdown_timer.
module tb_bcd_countdown_timer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ld0 = 1'b0, st0 = 1'b0, pa0 = 1'b0;
  logic ld1 = 1'b0, st1 = 1'b0, pa1 = 1'b0;
  logic [7:0] lv0 = '0, lv1 = '0;
  logic [7:0] q0, q1;
  logic busy0, done0, err0, busy1, done1, err1;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  bcd_countdown_timer #(.DIGITS(2), .PRESCALE(1), .PRESCALE_W(8)) dut0 (
    .clk(clk), .rst(rst), .load(ld0), .load_val(lv0), .start(st0), .pause(pa0),
    .Q(q0), .busy(busy0), .done(done0), .load_err(err0)
  );
  bcd_countdown_timer #(.DIGITS(2), .PRESCALE(3), .PRESCALE_W(8)) dut1 (
    .clk(clk), .rst(rst), .load(ld1), .load_val(lv1), .start(st1), .pause(pa1),
    .Q(q1), .busy(busy1), .done(done1), .load_err(err1)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction
  task automatic run_to_done0(input int max);
    int n = 0;
    while (!done0 && n < max) begin
      step();
      n++;
    end
    check("done0_reached", done0, 1);
    check("q0_zero_at_done", q0, 0);
    check("busy0_low_at_done", busy0, 0);
    step();
    check("done0_one_cycle", done0, 0);
  endtask
  initial begin
    step();
    step();
    rst = 1'b0;
    check("rst_q0", q0, 0);
    check("rst_busy0", busy0, 0);
    check("rst_done0", done0, 0);
    check("rst_err0", err0, 0);
    check("rst_q1", q1, 0);
    // load 25, count down to zero
    ld0 = 1; lv0 = 8'h25; step(); ld0 = 0;
    check("load25", q0, 8'h25);
    st0 = 1; step(); st0 = 0;
    check("run_busy", busy0, 1);
    check("run_first_q", q0, 8'h25);
    for (int i = 24; i >= 1; i--) begin
      step();
      check("cnt25_q", q0, bcd(i));
      check("cnt25_done", done0, 0);
    end
    step();
    check("cnt25_zero_q", q0, 8'h00);
    check("cnt25_done", done0, 1);
    check("cnt25_busy", busy0, 0);
    step();
    check("cnt25_done_drop", done0, 0);
    // load 10: first tick borrows to 09
    ld0 = 1; lv0 = 8'h10; step(); ld0 = 0;
    st0 = 1; step(); st0 = 0;
    step();
    check("borrow_09", q0, 8'h09);
    run_to_done0(15);
    // start with Q=0 is ignored
    ld0 = 1; lv0 = 8'h00; step(); ld0 = 0;
    st0 = 1; step(); st0 = 0;
    check("zero_start_busy", busy0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("zero_start_done", done0, 0);
      check("zero_start_q", q0, 0);
    end
    // invalid load, then load during RUN
    ld0 = 1; lv0 = 8'h12; step(); ld0 = 0;
    check("load12", q0, 8'h12);
    ld0 = 1; lv0 = 8'h3A; step(); ld0 = 0;
    check("bad_load_q", q0, 8'h12);
    check("bad_load_err", err0, 1);
    step();
    check("bad_load_err_drop", err0, 0);
    st0 = 1; step(); st0 = 0;
    step();
    check("run12_q", q0, 8'h11);
    ld0 = 1; lv0 = 8'h47; step(); ld0 = 0;
    check("run_load_ignored_q", q0, 8'h10);
    check("run_load_no_err", err0, 0);
    step();
    check("run_load_continue", q0, 8'h09);
    run_to_done0(15);
    // pause / resume from 15
    ld0 = 1; lv0 = 8'h15; step(); ld0 = 0;
    st0 = 1; step(); st0 = 0;
    pa0 = 1; step(); pa0 = 0;
    check("pause_q", q0, 8'h15);
    for (int i = 0; i < 5; i++) begin
      step();
      check("paused_q", q0, 8'h15);
      check("paused_busy", busy0, 1);
    end
    st0 = 1; pa0 = 1; step(); pa0 = 0;
    check("paused_both_q", q0, 8'h15);
    step(); st0 = 0;
    check("resume_q", q0, 8'h15);
    step();
    check("resume_dec", q0, 8'h14);
    st0 = 1; pa0 = 1; step(); st0 = 0; pa0 = 0;
    check("run_both_pause_q", q0, 8'h14);
    step();
    check("run_both_frozen", q0, 8'h14);
    check("run_both_busy", busy0, 1);
    st0 = 1; step(); st0 = 0;
    run_to_done0(20);
    // PRESCALE=3
    ld1 = 1; lv1 = 8'h02; step(); ld1 = 0;
    st1 = 1; step(); st1 = 0;
    step(); step();
    check("ps3_q_2cyc", q1, 8'h02);
    step();
    check("ps3_q_3cyc", q1, 8'h01);
    step(); step();
    check("ps3_q_5cyc", q1, 8'h01);
    check("ps3_done_early", done1, 0);
    step();
    check("ps3_q_6cyc", q1, 8'h00);
    check("ps3_done", done1, 1);
    check("ps3_busy", busy1, 0);
    // reset mid-run
    ld1 = 1; lv1 = 8'h05; step(); ld1 = 0;
    st1 = 1; step(); st1 = 0;
    repeat (4) step();
    check("ps3_mid_q", q1, 8'h04);
    rst = 1; step(); rst = 0;
    check("mid_rst_q", q1, 0);
    check("mid_rst_busy", busy1, 0);
    check("mid_rst_done", done1, 0);
    st1 = 1; step(); st1 = 0;
    check("post_rst_start_busy", busy1, 0);
    step();
    check("post_rst_q", q1, 0);
    check("post_rst_done", done1, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Multi-digit BCD down-counter (countdown timer). It is the decrementing counterpart of the team's mod-10 up-counter.
- Each digit is a mod-10 down stage. A borrow ripples from the least significant digit upward.
- A small control FSM handles load, start, pause and done.
- Used as the seconds/ticks countdown in display and timer subsystems. A host loads a BCD value, starts the timer and waits for the one-cycle done pulse.

Parameters:
- DIGITS, 2, number of BCD digits (must be ≥1).
- PRESCALE, 1, number of RUN cycles per decrement (must be ≥1).
- PRESCALE_W, 8, width of the prescaler counter (must satisfy 2^PRESCALE_W ≥ PRESCALE).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  load request; load_val is sampled on the same edge.
- load_val  in  4*DIGITS  BCD value to load; digit 0 is in bits [3:0].
- start  in  1  start from IDLE, or resume from PAUSED.
- pause  in  1  pause a running count.
- Q  out  4*DIGITS  current BCD count, registered.
- busy  out  1  high while in RUN or PAUSED.
- done  out  1  one-cycle pulse when the count reaches zero.
- load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset values: Q=0, state=IDLE, prescaler=0, busy=0, done=0, load_err=0.
- rst dominates every other input.
- States:
  - IDLE: Q is held.
  - RUN: the count is decrementing.
  - PAUSED: Q and the prescaler are frozen.
- busy is registered and equals (state != IDLE).
- Load rules:
  - A load is accepted only in IDLE or PAUSED. In RUN, load is ignored and load_err stays 0.
  - If any nibble of load_val is greater than 9, Q is unchanged and load_err=1 for the following cycle.
  - Otherwise Q takes load_val on that edge.
  - A load in PAUSED also clears the prescaler.
- IDLE transitions:
  - start with Q≠0 and no load on the same edge: go to RUN and clear the prescaler.
  - start with Q==0: ignored; done is not asserted.
  - load and start on the same edge: the load takes effect and start is ignored.
- RUN, each cycle:
  - If prescaler==PRESCALE-1: decrement Q and set prescaler to 0.
  - Otherwise: prescaler+1.
- With PRESCALE=1, Q decrements on every edge while in RUN. The first decrement happens on the edge after the one that entered RUN.
- Decrement rule:
  - Digit 0 decrements. A digit at 0 wraps to 9 and asserts borrow to the next digit.
  - Digit i decrements only when all lower digits are 0 (borrow chain).
- Reaching zero:
  - On the edge where Q goes from 1 to 0: state goes to IDLE.
  - In the following cycle: done=1, busy=0 and Q=0 are all visible together.
  - The count never wraps below zero.
- RUN with pause: go to PAUSED. If pause and start are both asserted, pause wins.
- PAUSED transitions:
  - start without pause: return to RUN; the prescaler resumes from its held value.
  - start and pause together: stay in PAUSED.
- done and load_err are each high for exactly one cycle per event.
- Inputs are assumed synchronous to clk; the block does no input synchronisation.

Decomposition:
- Shared package (timer_pkg) contains:
  - state encoding constants: ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSED=2'd2;
  - BCD_MAX=4'd9 and BCD_W=4.
- Sub-module bcd_down_digit:
  - Ports: clk, rst, load, d[3:0], dec_en, q[3:0], borrow_out.
  - borrow_out = dec_en && q==0.
  - The top level instantiates DIGITS copies in a generate loop. Each digit's dec_en is the previous digit's borrow_out; digit 0's dec_en is the tick.
  - The validity check (nibble ≤9) lives in the top level.

Test Plan:
- DIGITS=2, PRESCALE=1:
  - load 8'h25, then start → Q runs 0x24, 0x23, … 0x20, 0x19 (borrow) … 0x00 over 25 RUN cycles. done=1 for one cycle alongside Q=0x00; busy drops in that same cycle.
  - load 8'h10, start → the first tick gives Q=0x09 (digit 0 wraps, digit 1 borrows). Load 8'h00 then start → stays in IDLE, busy=0, done never pulses.
  - load 8'h3A in IDLE → load_err one-cycle pulse, Q unchanged from its prior value. load 8'h47 during RUN → ignored, no load_err, the count continues.
  - From 0x15: pause for 5 cycles → Q frozen at its value; start → resumes and reaches 0x00 with done. pause and start on the same edge in RUN → PAUSED.
- DIGITS=2, PRESCALE=3:
  - load 8'h02, start → Q=0x01 after 3 RUN cycles and 0x00 after 6, then done.
  - Assert rst mid-run → next cycle Q=0, busy=0, done=0, IDLE; a following start is ignored because Q=0.
